// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder. Adds two WIDTH-bit operands plus a
// carry-in, DIGIT_W bits per clock with the least significant digit first.
// A single DIGIT_W-bit adder slice and a registered carry do the work.
// A start/busy/done handshake controls it. The sum, carry-out and signed
// overflow registers update only when the last digit completes.
module serial_adder #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  // Reject parameter sets that cannot be split into whole digits.
  generate
    if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 1 and an integer multiple of DIGIT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT_W:0]         slice_res;
  logic [WIDTH+DIGIT_W-1:0] psum_ext;
  logic [WIDTH-1:0]         psum_shift;

  // Adder slice: low digit of each operand plus the running carry.
  always_comb begin
    slice_res = {1'b0, a_sr_q[DIGIT_W-1:0]}
              + {1'b0, b_sr_q[DIGIT_W-1:0]}
              + {{DIGIT_W{1'b0}}, carry_q};
  end

  // New digit enters the partial sum from the MSB end. The widened
  // concatenation avoids a zero-width slice when WIDTH == DIGIT_W.
  always_comb begin
    psum_ext   = {slice_res[DIGIT_W-1:0], psum_q};
    psum_shift = psum_ext[WIDTH+DIGIT_W-1:DIGIT_W];
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          psum_d  = '0;
          carry_d = c_in;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy    = 1'b1;
        a_sr_d  = a_sr_q >> DIGIT_W;
        b_sr_d  = b_sr_q >> DIGIT_W;
        carry_d = slice_res[DIGIT_W];
        psum_d  = psum_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          sum_d   = psum_shift;
          c_out_d = slice_res[DIGIT_W];
          ovf_d   = (a_msb_q == b_msb_q) && (psum_shift[WIDTH-1] != a_msb_q);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          psum_d  = '0;
          carry_d = c_in;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle parametrised adder: adds two WIDTH-bit operands plus carry-in, DIGIT_W bits per clock, LSB digit first.
- Processes one digit per cycle through a single DIGIT_W-bit adder slice with a registered carry.
- Provides the area-lean add path for the arithmetic blocks, with a start/busy/done handshake, carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be >= 1.
- DIGIT_W, 1, bits added per cycle. WIDTH must be an integer multiple of DIGIT_W; elaboration-time error otherwise.
- NUM_DIGITS, WIDTH/DIGIT_W, derived (localparam), number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled only when not busy
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- c_in  input  1  carry-in, captured when start is accepted
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, held until the next completion
- c_out  output  1  carry out of bit WIDTH-1
- overflow  output  1  two's-complement overflow of the signed add

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, sum=0, c_out=0, overflow=0.
  - Internal shift registers, carry register and digit counter all cleared.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, exactly one cycle.
- Start acceptance:
  - start is accepted on a rising edge when state is IDLE or DONE and start=1.
  - On acceptance: a, b load into shift registers; carry register loads c_in; digit counter loads 0; state goes to RUN.
- RUN, each edge:
  - {carry, digit} = a_sr[DIGIT_W-1:0] + b_sr[DIGIT_W-1:0] + carry. Width DIGIT_W+1; upper bit becomes the new carry.
  - Result digit shifts into a partial-sum register from the MSB end.
  - a_sr and b_sr shift right by DIGIT_W.
  - Counter increments.
- Completion (edge with counter = NUM_DIGITS-1, i.e. the final digit):
  - sum is loaded with the complete partial sum including the final digit.
  - c_out is loaded with the final carry.
  - overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]), using the captured operand MSBs.
  - state goes to DONE.
- Latency:
  - start accepted at edge k → busy high in cycles k+1 .. k+NUM_DIGITS.
  - done high in cycle k+NUM_DIGITS+1.
  - For WIDTH=16, DIGIT_W=1: done asserts 17 cycles after the accepting edge.
- sum, c_out and overflow change only at completion. They are stable in and after DONE until the next completion. Intermediate digits are never visible on the outputs.
- start while busy=1 is ignored; a/b/c_in changes during RUN have no effect.
- start=1 in DONE: accepted, state goes to RUN. Back-to-back throughput is one result per NUM_DIGITS+1 cycles.
- DONE with start=0: next state IDLE.
- rst_n low mid-RUN: operation is abandoned, all outputs return to reset values immediately, and done never asserts for that operation.
- WIDTH=DIGIT_W (NUM_DIGITS=1): one RUN cycle, then DONE. Must behave identically to a combinational full-width add plus registering.

Test Plan:
- WIDTH=1, DIGIT_W=1, all 8 {a,b,c_in} combinations → {c_out,sum} = 00,01,01,10,01,10,10,11 in order 000..111; done pulses 2 cycles after each accepting edge.
- WIDTH=16, DIGIT_W=1, a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, overflow=0; busy high exactly 16 cycles; done high exactly 1 cycle.
- WIDTH=16, DIGIT_W=4, a=0x7FFF, b=0x0001, c_in=0 → sum=0x8000, c_out=0, overflow=1; done 5 cycles after acceptance. Then a=0x8000, b=0x8000, c_in=1 → sum=0x0001, c_out=1, overflow=1.
- WIDTH=16, DIGIT_W=1, start held high throughout with a=0x1234, b=0x1111, c_in=0, operands changed to 0xAAAA/0x5555 mid-RUN:
  - first result is 0x2345, c_out=0;
  - second operation accepted in the DONE cycle completes with the new operands.
- Reset mid-RUN: rst_n low at cycle 8 of a 16-cycle add → busy, done, sum, c_out, overflow all 0 asynchronously. After release, a fresh start with 0x0003+0x0004 yields 0x0007.
- Random regression, WIDTH in {8,16,32}, DIGIT_W in {1,2,WIDTH}, 1000 operations each → {c_out,sum} equals a+b+c_in and overflow matches the reference model.
